// File: rtl/stream_mux_2x1.sv
// rtl/stream_mux_2x1.sv - registered 2:1 stream combiner with round-robin arbitration
// Define STREAM_MUX_FIXED_PRIO_EN for fixed src0-wins priority instead of round-robin.
module stream_mux_2x1 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din0,
  input  logic              din0_valid,
  output logic              din0_ready,
  input  logic [DATA_W-1:0] din1,
  input  logic              din1_valid,
  output logic              din1_ready,
  output logic [DATA_W-1:0] y,
  output logic              y_sel,
  output logic              y_valid,
  input  logic              y_ready
);

  logic load;
  logic g0;
  logic g1;

  // The output register can refill when empty or when drained this cycle.
  assign load = !y_valid | y_ready;

`ifdef STREAM_MUX_FIXED_PRIO_EN
  always_comb begin
    g0 = din0_valid;
    g1 = din1_valid & !din0_valid;
  end
`else
  logic rr_last;

  // On a tie the source that did not win last time is granted.
  always_comb begin
    g0 = din0_valid;
    g1 = din1_valid;
    if (din0_valid && din1_valid) begin
      g0 = rr_last;
      g1 = !rr_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= 1'b1;
    end else if (load && (g0 || g1)) begin
      rr_last <= g1;
    end
  end
`endif

  assign din0_ready = load & g0 & !rst;
  assign din1_ready = load & g1 & !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_sel   <= 1'b0;
      y_valid <= 1'b0;
    end else if (load) begin
      if (g0 || g1) begin
        y       <= g1 ? din1 : din0;
        y_sel   <= g1;
        y_valid <= 1'b1;
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/stream_mux_2x1.md
Name: stream_mux_2x1

Overview:
- Registered 2-to-1 stream combiner: merges two valid/ready input streams (src0, src1) onto one output stream.
- Functionally the inverse of the team's 1:2 demux. The demux routes one source to y0/y1 by sel. This block gathers two sources into one sink and reports which source won in y_sel, so a downstream demux can split the traffic back out.
- Round-robin arbitration with a single output register stage; sits between two producers and one shared consumer.

Parameters:
- DATA_W, 8, width of data on both inputs and the output.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din0  input  DATA_W  source 0 data.
- din0_valid  input  1  source 0 has data.
- din0_ready  output  1  source 0 beat accepted this cycle (combinational).
- din1  input  DATA_W  source 1 data.
- din1_valid  input  1  source 1 has data.
- din1_ready  output  1  source 1 beat accepted this cycle (combinational).
- y  output  DATA_W  output data (registered).
- y_sel  output  1  source index of the current y beat: 0 = din0, 1 = din1 (registered).
- y_valid  output  1  output holds a valid beat (registered).
- y_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (rst=1 at clk edge): y=0, y_sel=0, y_valid=0, rr_last=1 (so src0 wins the first tie). din0_ready and din1_ready are 0 while rst=1.
- Handshake: a transfer happens on an edge where valid=1 and ready=1. Once valid is asserted, the producer holds valid and data stable until the transfer.
- load = !y_valid | y_ready. The output register can take a new beat when it is empty or is being drained in the same cycle.
- Grant (combinational):
  - only din0_valid → g0;
  - only din1_valid → g1;
  - both valid → the source that is not rr_last;
  - neither → no grant.
- Ready outputs: din0_ready = load & g0 & !rst; din1_ready = load & g1 & !rst. At most one is high in any cycle.
- On load with a grant: y ← granted data, y_sel ← granted index, y_valid ← 1, rr_last ← granted index.
- On load with no grant: y_valid ← 0; y, y_sel and rr_last hold.
- When !load (y_valid=1, y_ready=0): y, y_sel, y_valid and rr_last all hold. Both input readys are 0.
- Latency: an accepted input beat appears on y one cycle later.
- Throughput: one beat per cycle with y_ready held at 1; there are no bubbles when inputs are continuously valid.
- Fairness: when both inputs are continuously valid, grants strictly alternate 0,1,0,1…
- A single active source gets every cycle; rr_last only shifts priority on ties.
- Reset mid-operation: a pending y beat is dropped (y_valid=0 on the next edge). No input is accepted in the reset cycle.

Optional Feature:
- Macro: STREAM_MUX_FIXED_PRIO_EN.
- Defined: round-robin is removed. On a tie src0 always wins, and rr_last is not implemented. src1 is served only when din0_valid=0 on the load cycle.
- Undefined: round-robin arbitration as described above.

Test Plan:
- Reset: assert rst for 2 cycles with both inputs valid → y_valid=0, y=0, y_sel=0, din0_ready=din1_ready=0. After release, the first tie grants src0.
- Single source: din0=8'hA5, valid only on src0, y_ready=1 → y=8'hA5 with y_sel=0 one cycle later; din1_ready stays 0.
- Contention: both valid continuously, din0=8'h11, din1=8'h22, y_ready=1 → y sequence 11,22,11,22 with y_sel 0,1,0,1. With STREAM_MUX_FIXED_PRIO_EN defined, the sequence is 11,11,11.
- Backpressure: y_ready=0 for 3 cycles after y=8'h11 is loaded → y=8'h11 and y_valid=1 held, din0_ready=din1_ready=0. When y_ready=1 returns, the next beat is 8'h22 from src1.
- Idle gap: inputs drop valid while y_ready=1 → y_valid falls to 0 the next cycle. When src1 later asserts alone with 8'h33, y=8'h33 and y_sel=1.
- Reset mid-stream: rst pulses while y_valid=1 → y_valid=0 next cycle. After release the next tie grants src0.
